boot_loader: RTL and testbench

//   Loads a program into the shared instruction/data block RAM over UART before the core runs.
//   - Receives bytes from the UART receiver, packs them into 32-bit words and writes them to BRAM.
//   - Holds the core in reset during loading, then hands the BRAM port to the core.
//   - Sits between core, uart_rx and the BRAM; owns the BRAM port mux and the core's rstn.

---
 rtl/boot_loader_if.sv | 28 ++
 rtl/boot_loader.sv | 158 +++++++++++++++
 tb/tb_boot_loader.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// boot_loader_if: groups the UART byte input, the core-side BRAM port, the muxed
// BRAM port and the loader status lines. The loader connects through the slave
// modport; whoever drives the UART bytes and the core port uses the master modport.
interface boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_din;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din;
    logic              core_rstn;
    logic              load_done;
    logic              load_err;

    modport master (
        output rx_valid, rx_data, core_we, core_addr, core_din,
        input  bram_we, bram_addr, bram_din, core_rstn, load_done, load_err
    );

    modport slave (
        input  rx_valid, rx_data, core_we, core_addr, core_din,
        output bram_we, bram_addr, bram_din, core_rstn, load_done, load_err
    );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: receives a little-endian program image over UART (4-byte word count N,
// then N*4 data bytes), packs it into 32-bit words written to BRAM addresses 0..N-1,
// holds the core in reset while loading and then hands the BRAM port to the core.
// Optional feature macro CHECKSUM_EN: a trailing byte equal to the XOR of all length
// and data bytes is required; a mismatch ends in the error state.
module boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic         clk,
    input  logic         rstn,
    boot_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [31:0]     MAX_N   = 32'(MAX_WORDS);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

`ifdef CHECKSUM_EN
    localparam state_t S_DONE = S_CSUM;
`else
    localparam state_t S_DONE = S_RUN;
`endif

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_byte_cnt, w_byte_cnt_nxt;
    logic [23:0]       r_shift, w_shift_nxt;
    logic [ADDR_W:0]   r_word_cnt, w_word_cnt_nxt;
    logic [ADDR_W:0]   r_len, w_len_nxt;
    logic              r_ld_we, w_ld_we_nxt;
    logic [ADDR_W-1:0] r_ld_addr, w_ld_addr_nxt;
    logic [31:0]       r_ld_din, w_ld_din_nxt;
    logic              r_run;
    logic              r_err;
`ifdef CHECKSUM_EN
    logic [7:0]        r_csum, w_csum_nxt;
`endif

    // Word formed if the current byte completes a 4-byte group (first byte lands in 7:0).
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_cnt_inc;

    assign w_word    = {bus.rx_data, r_shift};
    assign w_cnt_inc = r_word_cnt + CNT_ONE;

    // Next-state and next-register decode for the byte-stream parser.
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_shift_nxt    = r_shift;
        w_word_cnt_nxt = r_word_cnt;
        w_len_nxt      = r_len;
        w_ld_we_nxt    = 1'b0;
        w_ld_addr_nxt  = r_ld_addr;
        w_ld_din_nxt   = r_ld_din;
`ifdef CHECKSUM_EN
        w_csum_nxt     = r_csum;
`endif
        case (r_state)
            S_LEN: begin
                if (bus.rx_valid) begin
                    w_shift_nxt    = w_word[31:8];
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
`ifdef CHECKSUM_EN
                    w_csum_nxt     = r_csum ^ bus.rx_data;
`endif
                    if (r_byte_cnt == 2'd3) begin
                        if (w_word == 32'd0) begin
                            w_state_nxt = S_DONE;
                        end else if (w_word > MAX_N) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            w_len_nxt   = w_word[ADDR_W:0];
                            w_state_nxt = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    w_shift_nxt    = w_word[31:8];
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
`ifdef CHECKSUM_EN
                    w_csum_nxt     = r_csum ^ bus.rx_data;
`endif
                    if (r_byte_cnt == 2'd3) begin
                        w_ld_we_nxt    = 1'b1;
                        w_ld_addr_nxt  = r_word_cnt[ADDR_W-1:0];
                        w_ld_din_nxt   = w_word;
                        w_word_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
            end
`ifdef CHECKSUM_EN
            S_CSUM: begin
                if (bus.rx_valid) begin
                    w_state_nxt = (bus.rx_data == r_csum) ? S_RUN : S_ERR;
                end
            end
`endif
            default: begin
                // S_RUN and S_ERR are terminal until rstn; received bytes are ignored.
            end
        endcase
    end

    // Loader state and registered outputs; run/err follow the state one cycle later.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_LEN;
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
            r_word_cnt <= '0;
            r_len      <= '0;
            r_ld_we    <= 1'b0;
            r_ld_addr  <= '0;
            r_ld_din   <= 32'd0;
            r_run      <= 1'b0;
            r_err      <= 1'b0;
`ifdef CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_len      <= w_len_nxt;
            r_ld_we    <= w_ld_we_nxt;
            r_ld_addr  <= w_ld_addr_nxt;
            r_ld_din   <= w_ld_din_nxt;
            r_run      <= (r_state == S_RUN);
            r_err      <= (r_state == S_ERR);
`ifdef CHECKSUM_EN
            r_csum     <= w_csum_nxt;
`endif
        end
    end

    // BRAM port mux: the core owns the port only once the registered run flag is set.
    assign bus.bram_we   = r_run ? bus.core_we   : r_ld_we;
    assign bus.bram_addr = r_run ? bus.core_addr : r_ld_addr;
    assign bus.bram_din  = r_run ? bus.core_din  : r_ld_din;
    assign bus.core_rstn = r_run;
    assign bus.load_done = r_run;
    assign bus.load_err  = r_err;
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: drives byte streams into boot_loader and compares every cycle
// against a protocol-level model that decodes the received byte sequence.
module tb_boot_loader;
    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;
`ifdef CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: decodes the accepted byte sequence ----------------
    logic [7:0]        m_last [4];
    int                m_cnt;
    longint            m_n;
    logic [7:0]        m_x;
    bit                m_decided;
    int                m_pend;     // 0 none, 1 success, 2 error (visible one edge later)
    bit                m_run, m_err, m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [31:0]       m_wdin;
    logic [31:0]       m_word;
    logic [31:0]       m_log_din [$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt = 0; m_n = 0; m_x = 8'h00; m_decided = 1'b0; m_pend = 0;
            m_run = 1'b0; m_err = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdin = 32'd0;
            for (int i = 0; i < 4; i++) m_last[i] = 8'h00;
        end else begin
            m_we = 1'b0;
            if (m_pend == 1) m_run = 1'b1;
            else if (m_pend == 2) m_err = 1'b1;
            m_pend = 0;
            if (!m_decided && bus.rx_valid) begin
                m_last[m_cnt % 4] = bus.rx_data;
                m_cnt++;
                m_word = {m_last[3], m_last[2], m_last[1], m_last[0]};
                if (CSUM && m_cnt > 4 && m_cnt == 5 + 4 * m_n) begin
                    m_decided = 1'b1;
                    m_pend    = (bus.rx_data == m_x) ? 1 : 2;
                end else begin
                    m_x = m_x ^ bus.rx_data;
                    if (m_cnt == 4) begin
                        m_n = m_word;
                        if (m_n > MAX_WORDS) begin
                            m_decided = 1'b1; m_pend = 2;
                        end else if (m_n == 0 && !CSUM) begin
                            m_decided = 1'b1; m_pend = 1;
                        end
                    end else if (m_cnt > 4 && (m_cnt - 4) % 4 == 0) begin
                        m_we    = 1'b1;
                        m_waddr = ADDR_W'((m_cnt - 4) / 4 - 1);
                        m_wdin  = m_word;
                        m_log_din.push_back(m_word);
                        if ((m_cnt - 4) / 4 == m_n && !CSUM) begin
                            m_decided = 1'b1; m_pend = 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- compare process: every cycle, away from the active edge ----------------
    bit                chk_en = 1'b0;
    logic [ADDR_W-1:0] obs_addr [$];
    logic [31:0]       obs_din  [$];

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rstn) begin
                check("rst_bram_we",   bus.bram_we,   1'b0);
                check("rst_core_rstn", bus.core_rstn, 1'b0);
                check("rst_load_done", bus.load_done, 1'b0);
                check("rst_load_err",  bus.load_err,  1'b0);
            end else begin
                check("core_rstn", bus.core_rstn, m_run);
                check("load_done", bus.load_done, m_run);
                check("load_err",  bus.load_err,  m_err);
                if (m_run) begin
                    check("mux_we",   bus.bram_we,   bus.core_we);
                    check("mux_addr", bus.bram_addr, bus.core_addr);
                    check("mux_din",  bus.bram_din,  bus.core_din);
                end else begin
                    check("ld_we", bus.bram_we, m_we);
                    if (m_we) begin
                        check("ld_addr", bus.bram_addr, m_waddr);
                        check("ld_din",  bus.bram_din,  m_wdin);
                    end
                end
                if (bus.bram_we && !bus.load_done) begin
                    obs_addr.push_back(bus.bram_addr);
                    obs_din.push_back(bus.bram_din);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit         core_rand = 1'b1;
    logic [7:0] stim [$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (core_rand) begin
                bus.core_we   = 1'($urandom_range(0, 1));
                bus.core_addr = ADDR_W'($urandom);
                bus.core_din  = $urandom;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] q [$], input bit gaps);
        foreach (q[i]) begin
            if (gaps) begin
                bus.rx_valid = 1'b0;
                idle($urandom_range(0, 2));
            end
            bus.rx_valid = 1'b1;
            bus.rx_data  = q[i];
            tick();
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic add_word(input logic [31:0] w);
        stim.push_back(w[7:0]);
        stim.push_back(w[15:8]);
        stim.push_back(w[23:16]);
        stim.push_back(w[31:24]);
    endtask

    task automatic add_csum(input bit corrupt);
        logic [7:0] x = 8'h00;
        foreach (stim[i]) x = x ^ stim[i];
        stim.push_back(corrupt ? ~x : x);
    endtask

    task automatic clear_logs();
        obs_addr.delete();
        obs_din.delete();
        m_log_din.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle(3);
        rstn = 1'b1;
        clear_logs();
        stim.delete();
        idle(1);
    endtask

    task automatic wait_outcome(input string name, input int budget);
        int n = 0;
        while (!(bus.load_done || bus.load_err) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    logic [31:0] t2_words [3] = '{32'h11111111, 32'h22222222, 32'h33333333};

    initial begin
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        bus.core_we = 1'b0; bus.core_addr = '0; bus.core_din = 32'd0;
        chk_en = 1'b1;
        idle(2);

        // Reset state.
        @(negedge clk);
        check("reset_core_rstn", bus.core_rstn, 1'b0);
        check("reset_load_done", bus.load_done, 1'b0);
        check("reset_load_err",  bus.load_err,  1'b0);
        check("reset_bram_we",   bus.bram_we,   1'b0);
        tick();
        rstn = 1'b1;
        clear_logs();
        idle(1);

        // Single-word load: one write of 0x00A00513 at address 0, then release.
        stim = {8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
        send(stim, 1'b0);
        @(negedge clk);
        check("t1_we",         bus.bram_we,   1'b1);
        check("t1_addr",       bus.bram_addr, 32'h0);
        check("t1_din",        bus.bram_din,  32'h00A00513);
        check("t1_rstn_held",  bus.core_rstn, 1'b0);
        check("t1_model_din",  m_log_din[0],  32'h00A00513);
`ifdef CHECKSUM_EN
        stim = {8'hB7};
        send(stim, 1'b0);
`endif
        wait_outcome("t1", 10);
        @(negedge clk);
        check("t1_done",      bus.load_done, 1'b1);
        check("t1_core_rstn", bus.core_rstn, 1'b1);

        // Core owns the BRAM port after release.
        core_rand     = 1'b0;
        bus.core_we   = 1'b1;
        bus.core_addr = 8'h80;
        bus.core_din  = 32'hDEADBEEF;
        @(negedge clk);
        check("t4_we",   bus.bram_we,   1'b1);
        check("t4_addr", bus.bram_addr, 32'h80);
        check("t4_din",  bus.bram_din,  32'hDEADBEEF);
        core_rand = 1'b1;
        tick();

        // Three words back-to-back; core stays in reset through the last write.
        do_reset();
        add_word(32'd3);
        foreach (t2_words[i]) add_word(t2_words[i]);
        send(stim, 1'b0);
        @(negedge clk);
        check("t2_last_we",   bus.bram_we,   1'b1);
        check("t2_last_addr", bus.bram_addr, 32'h2);
        check("t2_last_din",  bus.bram_din,  32'h33333333);
        check("t2_rstn_held", bus.core_rstn, 1'b0);
        tick();
`ifdef CHECKSUM_EN
        check("t2_rstn_wait_csum", bus.core_rstn, 1'b0);
        stim = {8'h03};
        send(stim, 1'b0);
        tick();
`endif
        check("t2_released", bus.core_rstn, 1'b1);
        check("t2_nwrites",  32'(obs_addr.size()), 32'd3);
        check("t2_model_n",  32'(m_log_din.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("t2_addr", obs_addr[i], 32'(i));
            check("t2_din",  obs_din[i],  t2_words[i]);
        end

        // Oversized length: error, no write, later bytes ignored.
        do_reset();
        stim = {8'h01, 8'h01, 8'h00, 8'h00};
        send(stim, 1'b0);
        idle(2);
        check("t3_err",       bus.load_err,  1'b1);
        check("t3_core_rstn", bus.core_rstn, 1'b0);
        check("t3_nwrites",   32'(obs_addr.size()), 32'd0);
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
        send(stim, 1'b1);
        idle(2);
        check("t3_err_sticky", bus.load_err,  1'b1);
        check("t3_no_done",    bus.load_done, 1'b0);
        check("t3_nwrites2",   32'(obs_addr.size()), 32'd0);

        // Reset mid-word aborts the load; a fresh load restarts at address 0.
        do_reset();
        stim = {8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        send(stim, 1'b0);
        #3;
        rstn = 1'b0;
        @(negedge clk);
        check("t5_rst_we",   bus.bram_we,   1'b0);
        check("t5_rst_rstn", bus.core_rstn, 1'b0);
        check("t5_rst_err",  bus.load_err,  1'b0);
        tick();
        rstn = 1'b1;
        clear_logs();
        idle(1);
        stim = {8'h01, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
`ifdef CHECKSUM_EN
        stim.push_back(8'hC8);
`endif
        send(stim, 1'b1);
        wait_outcome("t5", 10);
        check("t5_done",    bus.load_done, 1'b1);
        check("t5_nwrites", 32'(obs_addr.size()), 32'd1);
        check("t5_addr",    obs_addr[0], 32'h0);
        check("t5_din",     obs_din[0],  32'hCAFEF00D);

`ifdef CHECKSUM_EN
        // Checksum accepted / rejected.
        do_reset();
        stim = {8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        send(stim, 1'b0);
        wait_outcome("t6a", 10);
        check("t6a_done", bus.load_done, 1'b1);
        do_reset();
        stim = {8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
        send(stim, 1'b0);
        wait_outcome("t6b", 10);
        check("t6b_err",       bus.load_err,  1'b1);
        check("t6b_core_rstn", bus.core_rstn, 1'b0);
`endif

        // Full-size program: N = 2**ADDR_W ends at address 255 without wrap.
        do_reset();
        add_word(32'd256);
        for (int i = 0; i < 256; i++) add_word($urandom);
        if (CSUM) add_csum(1'b0);
        send(stim, 1'b0);
        wait_outcome("tmax", 10);
        check("tmax_done",      bus.load_done, 1'b1);
        check("tmax_nwrites",   32'(obs_addr.size()), 32'd256);
        check("tmax_last_addr", obs_addr[255], 32'hFF);

        // Randomized loads with gaps, junk tails, bad lengths and truncated streams.
        for (int it = 0; it < 16; it++) begin
            int          sel;
            logic [31:0] n;
            do_reset();
            sel = $urandom_range(0, 9);
            if (sel < 7)       n = $urandom_range(0, 6);
            else if (sel == 7) n = 32'd257;
            else if (sel == 8) n = $urandom | 32'h0000_0200;
            else               n = 32'd256;
            add_word(n);
            if (n <= 32'(MAX_WORDS)) begin
                for (int w = 0; w < int'(n); w++) add_word($urandom);
            end
            if (CSUM) add_csum($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) stim.push_back(8'($urandom));
            if ($urandom_range(0, 5) == 0) stim = stim[0:$urandom_range(0, stim.size() - 1)];
            send(stim, 1'($urandom_range(0, 1)));
            idle(4);
        end

        idle(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
